// File: rtl/ycbcr_block_sequencer.sv
// Block sequencer for the 64-lane RGB->YCbCr array.
// Fills an 8x8 RGB block, freezes it while the converter settles, then hands it off.
//
// Ports:
//   clk, rst_n                   clock and async active-low reset
//   pix_valid/pix_ready          upstream pixel handshake
//   pix_r/g/b, pix_last          pixel components and end-of-block marker
//   r_all/g_all/b_all            frozen block buses to the converter
//   blk_valid/blk_ready          downstream block handshake
//   busy                         a block is partially filled, settling or held
//   blk_count                    blocks handed off (wraps)
//   err_sync                     sticky pix_last framing error
module ycbcr_block_sequencer #(
    parameter int INPUT_WIDTH   = 8,
    parameter int PIXELS        = 64,
    parameter int CONV_LATENCY  = 4,
    parameter int BLK_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [INPUT_WIDTH-1:0]        pix_r,
    input  logic [INPUT_WIDTH-1:0]        pix_g,
    input  logic [INPUT_WIDTH-1:0]        pix_b,
    input  logic                          pix_last,
    output logic [INPUT_WIDTH*PIXELS-1:0] r_all,
    output logic [INPUT_WIDTH*PIXELS-1:0] g_all,
    output logic [INPUT_WIDTH*PIXELS-1:0] b_all,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic                          busy,
    output logic [BLK_CNT_WIDTH-1:0]      blk_count,
    output logic                          err_sync
);

    localparam int BUS_W = INPUT_WIDTH * PIXELS;
    localparam int CW    = $clog2(CONV_LATENCY + 1);

    localparam logic [5:0]    LAST_IDX = 6'(PIXELS - 1);
    localparam logic [CW-1:0] LAT      = CW'(CONV_LATENCY);

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        HOLD
    } state_t;

    state_t                   state, state_n;
    logic [5:0]               idx, idx_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [BUS_W-1:0]         r_n, g_n, b_n;
    logic                     ready_n, valid_n, busy_n, err_n;
    logic [BLK_CNT_WIDTH-1:0] count_n;
    logic                     accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            cnt       <= '0;
            r_all     <= '0;
            g_all     <= '0;
            b_all     <= '0;
            pix_ready <= 1'b0;
            blk_valid <= 1'b0;
            busy      <= 1'b0;
            blk_count <= '0;
            err_sync  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            r_all     <= r_n;
            g_all     <= g_n;
            b_all     <= b_n;
            pix_ready <= ready_n;
            blk_valid <= valid_n;
            busy      <= busy_n;
            blk_count <= count_n;
            err_sync  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        r_n     = r_all;
        g_n     = g_all;
        b_n     = b_all;
        ready_n = pix_ready;
        valid_n = blk_valid;
        count_n = blk_count;
        err_n   = err_sync;
        accept  = pix_valid && pix_ready;

        unique case (state)
            FILL: begin
                ready_n = 1'b1;
                if (accept) begin
                    r_n[idx*INPUT_WIDTH +: INPUT_WIDTH] = pix_r;
                    g_n[idx*INPUT_WIDTH +: INPUT_WIDTH] = pix_g;
                    b_n[idx*INPUT_WIDTH +: INPUT_WIDTH] = pix_b;
                    if (idx == LAST_IDX) begin
                        // Missing marker is flagged but the block still goes out.
                        if (!pix_last) err_n = 1'b1;
                        idx_n   = '0;
                        cnt_n   = LAT;
                        ready_n = 1'b0;
                        state_n = WAIT;
                    end else if (pix_last) begin
                        // Early marker: restart the block, stale lanes get overwritten.
                        err_n = 1'b1;
                        idx_n = '0;
                    end else begin
                        idx_n = idx + 6'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(1)) begin
                    cnt_n   = '0;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    valid_n = 1'b0;
                    count_n = blk_count + BLK_CNT_WIDTH'(1);
                    ready_n = 1'b1;
                    state_n = FILL;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase

        busy_n = (state_n != FILL) || (idx_n != '0);
    end

endmodule

// File: doc/ycbcr_block_sequencer.md
Name: ycbcr_block_sequencer

Overview:
- Sequences the 64-lane RGB→YCbCr conversion array.
- Accepts a raster stream of RGB pixels, one per handshake, and assembles them into an 8x8 block register that drives the converter's r_all/g_all/b_all buses.
- Freezes that register while the converter pipeline settles, then presents the block as valid to the downstream DCT/quantiser stage with a valid/ready handshake.
- Frozen inputs keep the converter's y_all/cb_all/cr_all outputs stable for as long as blk_valid is high.

Parameters:
- INPUT_WIDTH, 8: bits per colour component.
- PIXELS, 64: pixels per block. Fixed at 64 for this design; the index counter is 6 bits.
- CONV_LATENCY, 4: converter pipeline depth in clk cycles. Must be >= 1.
- BLK_CNT_WIDTH, 16: width of the completed-block counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  upstream pixel valid.
- pix_ready  out  1  sequencer can accept a pixel.
- pix_r  in  INPUT_WIDTH  red component.
- pix_g  in  INPUT_WIDTH  green component.
- pix_b  in  INPUT_WIDTH  blue component.
- pix_last  in  1  upstream marks the final (64th) pixel of a block.
- r_all  out  INPUT_WIDTH*PIXELS  block red bus to the converter.
- g_all  out  INPUT_WIDTH*PIXELS  block green bus to the converter.
- b_all  out  INPUT_WIDTH*PIXELS  block blue bus to the converter.
- blk_valid  out  1  converter outputs are settled and the block is presented downstream.
- blk_ready  in  1  downstream consumes the block.
- busy  out  1  a block is in progress (partial fill, waiting, or holding).
- blk_count  out  BLK_CNT_WIDTH  number of blocks handed off.
- err_sync  out  1  sticky pix_last framing error.

Behaviour:
- Reset values (asynchronous, while rst_n=0): state=FILL, idx=0, wait counter=0, r_all/g_all/b_all=0, pix_ready=0, blk_valid=0, busy=0, blk_count=0, err_sync=0. All outputs are registered.
- pix_ready goes to 1 on the first clk edge after rst_n deasserts.
- Accept: an accept occurs when pix_valid && pix_ready at a rising edge. The pixel is written to lane idx (bits idx*INPUT_WIDTH +: INPUT_WIDTH of each bus). Lane 0 is the first pixel of the block.
- FILL state:
  - pix_ready=1. Each accept increments idx.
  - Gaps (pix_valid=0) hold all state.
  - Accepting lane 63 sets idx←0 and moves to WAIT with the counter loaded to CONV_LATENCY. pix_ready is 0 from the next cycle.
- WAIT state:
  - pix_ready=0; buses frozen. The counter decrements each edge.
  - If the 64th accept occurs at edge N, blk_valid rises at edge N+CONV_LATENCY, and the state becomes HOLD on the same edge.
- HOLD state:
  - blk_valid=1; buses frozen; pix_ready=0.
  - On an edge with blk_ready=1: blk_valid←0, blk_count←blk_count+1 (wraps modulo 2^BLK_CNT_WIDTH), state←FILL, pix_ready←1. The handoff edge accepts no pixel.
  - blk_ready while not in HOLD is ignored.
- busy: 1 whenever state≠FILL or idx≠0.
- Framing errors:
  - Accept with pix_last=1 at idx≠63: err_sync←1, idx←0, partial block discarded (stale lanes are overwritten by the next block), stay in FILL.
  - Accept at idx=63 with pix_last=0: err_sync←1, block proceeds normally.
  - err_sync is cleared only by reset.
- Reset mid-operation: everything returns to reset values immediately (blk_valid drops asynchronously); the partial or held block is lost.
- No overlap of fill and conversion: at most one block is in flight.

Test Plan:
- Basic block: 64 back-to-back accepts with r=i, g=2i mod 256, b=255-i, pix_last on i=63, blk_ready=1 → blk_valid rises exactly 4 cycles after the 64th accept; r_all[8i+:8]=i; b_all[7:0]=255; blk_count 0→1 on the handoff; pix_ready=1 on the following cycle.
- Backpressure: blk_ready=0 for 20 cycles after blk_valid → blk_valid, r_all/g_all/b_all and pix_ready=0 all stable; raising blk_ready → one-cycle handoff and blk_count increments once.
- Gapped input: pix_valid toggling 1/0 for 128 cycles → exactly 64 accepts fill lanes 0..63 in order; timing of blk_valid is still measured from the 64th accept.
- Early pix_last at lane 10 → err_sync=1, idx=0; the next 64 pixels form a correct block and err_sync stays 1.
- Reset mid-fill after 30 accepts → all outputs return to reset values; after release a full 64-pixel block completes normally with blk_count=1.
- Counter wrap with BLK_CNT_WIDTH=2: 4 blocks handed off → blk_count sequence 1,2,3,0.
